// File: rtl/umi_arb_pkg.sv
// Shared definitions for the ebrick UMI request arbiter and its round-robin picker.
package umi_arb_pkg;

    localparam int unsigned EOMBIT_DEFAULT = 22;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    // Requester id width; never collapses to zero bits.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ebrick_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping mod N.
module ebrick_rr_pick
    import umi_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [2*N-1:0] rot;
    logic           found;
    logic [31:0]    sum;

    // Rotate so bit 0 is the ptr requester, then take the lowest set bit.
    always_comb begin
        rot    = {valid, valid} >> ptr;
        found  = 1'b0;
        sum    = '0;
        gnt_id = '0;
        gnt    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = 32'(ptr) + 32'(k);
                if (sum >= 32'(N)) begin
                    sum = sum - 32'(N);
                end
                gnt_id = IW'(sum);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            gnt[j] = found && (gnt_id == IW'(j));
        end
    end

endmodule

// File: rtl/ebrick_umi_req_arbiter.sv
// Merges N UMI request streams onto one port: round-robin per transaction,
// grant held until the EOM beat, single registered output stage.
module ebrick_umi_req_arbiter
    import umi_arb_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned CW     = 32,
    parameter int unsigned AW     = 64,
    parameter int unsigned DW     = 64,
    parameter int unsigned EOMBIT = EOMBIT_DEFAULT,
    localparam int unsigned IW    = id_width(N)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*CW-1:0] in_cmd,
    input  logic [N*AW-1:0] in_dstaddr,
    input  logic [N*AW-1:0] in_srcaddr,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [CW-1:0]   out_cmd,
    output logic [AW-1:0]   out_dstaddr,
    output logic [AW-1:0]   out_srcaddr,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic [IW-1:0]   grant_id,
    output logic            locked
);

    arb_state_e     state;
    logic [IW-1:0]  ptr;
    logic [N-1:0]   pick_gnt;
    logic [IW-1:0]  pick_id;

    logic           load;
    logic [IW-1:0]  gnt;
    logic           accept;
    logic [CW-1:0]  sel_cmd;
    logic [AW-1:0]  sel_dstaddr;
    logic [AW-1:0]  sel_srcaddr;
    logic [DW-1:0]  sel_data;
    logic           sel_eom;
    logic [31:0]    ptr_sum;
    logic [IW-1:0]  ptr_nxt;

    ebrick_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid  (in_valid),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    // Grant, ready and payload select; while locked only the owner may be heard.
    always_comb begin
        load        = ~out_valid | out_ready;
        gnt         = (state == LOCKED) ? grant_id : pick_id;
        in_ready    = '0;
        sel_cmd     = '0;
        sel_dstaddr = '0;
        sel_srcaddr = '0;
        sel_data    = '0;
        if (nreset && load) begin
            if (state == LOCKED) begin
                for (int unsigned i = 0; i < N; i++) begin
                    in_ready[i] = (grant_id == IW'(i));
                end
            end else begin
                in_ready = pick_gnt;
            end
        end
        accept = |(in_valid & in_ready);
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt == IW'(i)) begin
                sel_cmd     = in_cmd[i*CW +: CW];
                sel_dstaddr = in_dstaddr[i*AW +: AW];
                sel_srcaddr = in_srcaddr[i*AW +: AW];
                sel_data    = in_data[i*DW +: DW];
            end
        end
        sel_eom = sel_cmd[EOMBIT];
        ptr_sum = 32'(gnt) + 32'd1;
        if (ptr_sum >= 32'(N)) begin
            ptr_sum = '0;
        end
        ptr_nxt = IW'(ptr_sum);
    end

    // Output stage, lock FSM and fairness pointer.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= UNLOCKED;
            ptr         <= '0;
            grant_id    <= '0;
            out_valid   <= 1'b0;
            out_cmd     <= '0;
            out_dstaddr <= '0;
            out_srcaddr <= '0;
            out_data    <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_cmd     <= sel_cmd;
            out_dstaddr <= sel_dstaddr;
            out_srcaddr <= sel_srcaddr;
            out_data    <= sel_data;
            grant_id    <= gnt;
            // EOM ends (or never opens) a transaction; anything else holds the lock.
            case (state)
                UNLOCKED: if (!sel_eom) state <= LOCKED;
                LOCKED:   if (sel_eom)  state <= UNLOCKED;
                default:  state <= UNLOCKED;
            endcase
            if (sel_eom) begin
                ptr <= ptr_nxt;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_ebrick_umi_req_arbiter.sv
// Directed bench for ebrick_umi_req_arbiter: reset, fairness, lock, backpressure,
// stall inside a lock and reset mid-transaction.
module tb_ebrick_umi_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    in_valid;
    logic [N*CW-1:0] in_cmd;
    logic [N*AW-1:0] in_dstaddr;
    logic [N*AW-1:0] in_srcaddr;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [CW-1:0]   out_cmd;
    logic [AW-1:0]   out_dstaddr;
    logic [AW-1:0]   out_srcaddr;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            locked;

    int tests = 0;
    int fails = 0;

    ebrick_umi_req_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .EOMBIT(22)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .in_valid    (in_valid),
        .in_cmd      (in_cmd),
        .in_dstaddr  (in_dstaddr),
        .in_srcaddr  (in_srcaddr),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_cmd     (out_cmd),
        .out_dstaddr (out_dstaddr),
        .out_srcaddr (out_srcaddr),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] mk_cmd(input logic eom, input logic [DW-1:0] d);
        return {9'h0, eom, 6'h0, d[15:0]};
    endfunction

    function automatic logic [AW-1:0] mk_dst(input logic [DW-1:0] d);
        return d ^ 64'hDDDD_0000_DDDD_0000;
    endfunction

    function automatic logic [AW-1:0] mk_src(input logic [DW-1:0] d);
        return d ^ 64'h5555_AAAA_0000_5555;
    endfunction

    task automatic set_req(input int i, input logic v, input logic eom, input logic [DW-1:0] d);
        in_valid[i]          = v;
        in_cmd[i*CW +: CW]   = mk_cmd(eom, d);
        in_dstaddr[i*AW +: AW] = mk_dst(d);
        in_srcaddr[i*AW +: AW] = mk_src(d);
        in_data[i*DW +: DW]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 1'b1, 64'(i));
        repeat (3) tick();
        tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b exp=0", locked); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        tests++; if (out_data !== 64'd0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        nreset = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_rdy;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_rdy = 4'b0001 << ((k + 1) % 4);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fair_valid[%0d] got=%b exp=1", k, out_valid); end
            tests++; if (out_data !== 64'(k % 4)) begin fails++; $display("FAIL fair_data[%0d] got=%h exp=%h", k, out_data, 64'(k % 4)); end
            tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy); end
        end
        tests++; if (out_dstaddr !== mk_dst(64'd3)) begin fails++; $display("FAIL fair_dstaddr got=%h exp=%h", out_dstaddr, mk_dst(64'd3)); end
        tests++; if (out_srcaddr !== mk_src(64'd3)) begin fails++; $display("FAIL fair_srcaddr got=%h exp=%h", out_srcaddr, mk_src(64'd3)); end
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, 1'b1, 64'd0);
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fair_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_lock();
        set_req(1, 1'b1, 1'b1, 64'h110);
        #1;
        tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL lock_pre_ready got=%b exp=0010", in_ready); end
        tick();
        set_req(1, 1'b0, 1'b1, 64'h0);
        set_req(0, 1'b1, 1'b1, 64'h100);
        set_req(2, 1'b1, 1'b0, 64'h200);
        set_req(3, 1'b1, 1'b1, 64'h300);
        #1;
        tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL lock_b0_ready got=%b exp=0100", in_ready); end
        tick();
        tests++; if (out_data !== 64'h200) begin fails++; $display("FAIL lock_b0_data got=%h exp=200", out_data); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_b0_locked got=%b exp=1", locked); end
        tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL lock_b0_gid got=%0d exp=2", grant_id); end
        set_req(2, 1'b1, 1'b0, 64'h201);
        #1;
        tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL lock_b1_ready got=%b exp=0100", in_ready); end
        tick();
        tests++; if (out_data !== 64'h201) begin fails++; $display("FAIL lock_b1_data got=%h exp=201", out_data); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_b1_locked got=%b exp=1", locked); end
        set_req(2, 1'b1, 1'b1, 64'h202);
        tick();
        tests++; if (out_data !== 64'h202) begin fails++; $display("FAIL lock_b2_data got=%h exp=202", out_data); end
        tests++; if (out_cmd !== mk_cmd(1'b1, 64'h202)) begin fails++; $display("FAIL lock_b2_cmd got=%h exp=%h", out_cmd, mk_cmd(1'b1, 64'h202)); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_b2_unlocked got=%b exp=0", locked); end
        set_req(2, 1'b0, 1'b1, 64'h0);
        #1;
        tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL lock_next_ready got=%b exp=1000", in_ready); end
        tick();
        tests++; if (out_data !== 64'h300) begin fails++; $display("FAIL lock_next3_data got=%h exp=300", out_data); end
        set_req(3, 1'b0, 1'b1, 64'h0);
        tick();
        tests++; if (out_data !== 64'h100) begin fails++; $display("FAIL lock_next0_data got=%h exp=100", out_data); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL lock_next0_gid got=%0d exp=0", grant_id); end
        set_req(0, 1'b0, 1'b1, 64'h0);
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lock_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        set_req(1, 1'b1, 1'b1, 64'h111);
        tick();
        tests++; if (out_data !== 64'h111) begin fails++; $display("FAIL bp_load_data got=%h exp=111", out_data); end
        out_ready = 1'b0;
        set_req(1, 1'b0, 1'b1, 64'h0);
        set_req(2, 1'b1, 1'b1, 64'h222);
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid); end
            tests++; if (out_data !== 64'h111 || out_cmd !== mk_cmd(1'b1, 64'h111)) begin
                fails++; $display("FAIL bp_stable[%0d] got=%h/%h exp=111/%h", c, out_data, out_cmd, mk_cmd(1'b1, 64'h111));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 64'h222) begin
            fails++; $display("FAIL bp_refill got=%b/%h exp=1/222", out_valid, out_data);
        end
        set_req(2, 1'b0, 1'b1, 64'h0);
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall_in_lock();
        set_req(1, 1'b1, 1'b0, 64'h410);
        #1;
        tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL stall_b0_ready got=%b exp=0010", in_ready); end
        tick();
        tests++; if (out_data !== 64'h410 || locked !== 1'b1) begin
            fails++; $display("FAIL stall_b0 got=%h/%b exp=410/1", out_data, locked);
        end
        set_req(1, 1'b0, 1'b0, 64'h0);
        set_req(0, 1'b1, 1'b1, 64'h400);
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL stall_ready[%0d] got=%b exp=0010", c, in_ready); end
            tests++; if (locked !== 1'b1) begin fails++; $display("FAIL stall_locked[%0d] got=%b exp=1", c, locked); end
            tick();
        end
        tests++; if (out_valid !== 1'b0 || grant_id !== 2'd1) begin
            fails++; $display("FAIL stall_idle got=%b/%0d exp=0/1", out_valid, grant_id);
        end
        set_req(1, 1'b1, 1'b1, 64'h411);
        tick();
        tests++; if (out_data !== 64'h411 || locked !== 1'b0) begin
            fails++; $display("FAIL stall_eom got=%h/%b exp=411/0", out_data, locked);
        end
        set_req(1, 1'b0, 1'b1, 64'h0);
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL stall_after_ready got=%b exp=0001", in_ready); end
        tick();
        tests++; if (out_data !== 64'h400) begin fails++; $display("FAIL stall_after_data got=%h exp=400", out_data); end
        set_req(0, 1'b0, 1'b1, 64'h0);
        tick();
    endtask

    task automatic test_mid_reset();
        set_req(3, 1'b1, 1'b0, 64'h530);
        #1;
        tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL mrst_pre_ready got=%b exp=1000", in_ready); end
        tick();
        tests++; if (locked !== 1'b1 || grant_id !== 2'd3) begin
            fails++; $display("FAIL mrst_locked got=%b/%0d exp=1/3", locked, grant_id);
        end
        set_req(3, 1'b1, 1'b1, 64'h531);
        set_req(0, 1'b1, 1'b1, 64'h500);
        nreset = 1'b0;
        #1;
        tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL mrst_ready_low got=%b exp=0000", in_ready); end
        tick();
        tests++; if (locked !== 1'b0 || out_valid !== 1'b0 || grant_id !== 2'd0 || out_data !== 64'd0) begin
            fails++; $display("FAIL mrst_state got=%b/%b/%0d/%h exp=0/0/0/0", locked, out_valid, grant_id, out_data);
        end
        nreset = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL mrst_first_ready got=%b exp=0001", in_ready); end
        tick();
        tests++; if (out_data !== 64'h500 || grant_id !== 2'd0) begin
            fails++; $display("FAIL mrst_first got=%h/%0d exp=500/0", out_data, grant_id);
        end
        #1;
        tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL mrst_second_ready got=%b exp=1000", in_ready); end
        tick();
        tests++; if (out_data !== 64'h531 || grant_id !== 2'd3) begin
            fails++; $display("FAIL mrst_second got=%h/%0d exp=531/3", out_data, grant_id);
        end
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, 1'b1, 64'd0);
        tick();
    endtask

    initial begin
        in_valid   = '0;
        in_cmd     = '0;
        in_dstaddr = '0;
        in_srcaddr = '0;
        in_data    = '0;
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_stall_in_lock();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ebrick_umi_req_arbiter.md
Name: ebrick_umi_req_arbiter

Overview:
- Shares one FPGA-visible UMI request port between N ebrick core UMI request streams.
- Needed because the FPGA exposes fewer UMI ports than the core has host channels.
- Round-robin arbitration per transaction, with the grant locked until the end-of-message beat.
- One registered output stage, so output timing is decoupled from the requesters.

Parameters:
- N, 4, number of requesters (2..8)
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 64, UMI data width
- EOMBIT, 22, bit index of the EOM flag within cmd

Ports:
- clk  input  1  single clock
- nreset  input  1  synchronous active-low reset
- in_valid  input  N  per-requester request valid
- in_cmd  input  N*CW  packed commands, requester i at [i*CW +: CW]
- in_dstaddr  input  N*AW  packed destination addresses
- in_srcaddr  input  N*AW  packed source addresses
- in_data  input  N*DW  packed data
- in_ready  output  N  per-requester ready
- out_valid  output  1  merged request valid
- out_cmd  output  CW  merged command
- out_dstaddr  output  AW  merged destination address
- out_srcaddr  output  AW  merged source address
- out_data  output  DW  merged data
- out_ready  input  1  downstream ready
- grant_id  output  clog2(N)  id of the requester in the current or last grant (status)
- locked  output  1  1 = mid-transaction lock held

Behaviour:
- Reset (nreset low at a clk edge):
  - out_valid=0, locked=0, grant_id=0, round-robin pointer ptr=0.
  - out_cmd/addr/data=0.
  - in_ready=0 while nreset is low.
- Buffer state:
  - load = ~out_valid | out_ready.
  - Beat accepted from requester i when in_valid[i] & in_ready[i].
- Grant (combinational):
  - UNLOCKED: gnt = first i with in_valid[i], searching ptr, ptr+1, ... mod N.
  - LOCKED: gnt = grant_id only, even if other requesters are valid.
- in_ready[i] = load & (i == gnt) & (UNLOCKED ? in_valid[i] : 1). At most one bit of in_ready is high.
- On accept:
  - The output register captures cmd/dstaddr/srcaddr/data of gnt.
  - out_valid=1 the next cycle (latency 1).
  - grant_id <= gnt.
- If out_valid & out_ready and no new accept: out_valid <= 0. Simultaneous drain and refill keeps out_valid=1 with new data, giving full throughput.
- FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on accepting a beat with cmd[EOMBIT]=0.
  - LOCKED -> UNLOCKED on accepting a beat from grant_id with cmd[EOMBIT]=1.
  - Single-beat EOM=1 transaction: stays UNLOCKED.
- Pointer update: on accepting an EOM=1 beat, ptr <= (gnt+1) mod N. No other event changes ptr.
- Locked requester deasserts valid mid-transaction: hold the lock and wait indefinitely; others stay blocked.
- Downstream stall (out_ready=0, out_valid=1): all in_ready=0; output payload stable until the handshake.
- Payload/valid rules:
  - out_valid never drops without out_ready.
  - out_* fields stay stable while out_valid & ~out_ready.
- Reset mid-transaction:
  - Lock and buffered beat are discarded, ptr=0.
  - Requesters must restart their transactions.
- No payload modification: cmd, addresses and data pass through bit-exact.

Decomposition:
- Shared package umi_arb_pkg:
  - EOMBIT default.
  - State encoding UNLOCKED=1'b0, LOCKED=1'b1.
  - Function for the clog2(N) id width.
- One natural sub-module, ebrick_rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: valid vector and ptr. Outputs: one-hot gnt and gnt id.
  - Reusable by the response-side demux/arbiters.

Test Plan:
- Reset: hold nreset=0 for 3 clks with all in_valid=1 -> in_ready=0, out_valid=0, locked=0; the first grant after release goes to requester 0.
- Fairness: N=4, all requesters continuously send single-beat EOM=1 packets with data=id, out_ready=1 -> output data sequence 0,1,2,3,0,1,...; one beat per cycle after 1-cycle latency.
- Lock:
  - Requester 2 sends 3 beats with EOM=0,0,1 while requesters 0 and 3 are valid.
  - Required: all 3 beats from 2 are contiguous with locked=1 during them.
  - Next grant goes to 3, then 0.
- Backpressure: out_ready=0 for 5 cycles with a beat held -> out_* stable, all in_ready=0; on out_ready=1 the beat drains and the next beat loads the same cycle.
- Stall inside lock: requester 1 sends an EOM=0 beat then drops valid for 4 cycles while 0 is valid -> no beat from 0 is accepted until requester 1's EOM=1 beat.
- Mid-transaction reset: reset pulse while locked on requester 3 -> locked=0, out_valid=0, ptr=0; requester 0 is granted first afterwards.
